// File: rtl/adc_pkg.sv
// Shared constants, FSM state encoding and config-word packing for the ADC scan scheduler.
package adc_pkg;
    localparam int NCH          = 8;
    localparam int CH_W         = $clog2(NCH);
    localparam int DATA_W       = 12;
    localparam int CFG_W        = 6;
    localparam int SHIFT_CYCLES = 24;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CONV,
        ST_SHIFT,
        ST_DONE
    } state_t;

    // Transmit order is MSB first: start bit, channel bits in the ADC's order, polarity, pad.
    function automatic logic [CFG_W-1:0] cfg_word(input logic [CH_W-1:0] ch, input logic uni);
        return {1'b1, ch[0], ch[2], ch[1], uni, 1'b0};
    endfunction
endpackage

// File: rtl/adc_frame.sv
// One ADC frame: CONV hold, 24-cycle serial exchange, one DONE cycle; owns the FSM and shift registers.
module adc_frame
    import adc_pkg::*;
#(
    parameter int CONV_CYCLES = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [CH_W-1:0]   ch,
    input  logic              uni,
    input  logic              dout,
    output state_t            state,
    output logic              done,
    output logic [DATA_W-1:0] data,
    output logic              cs,
    output logic              sclk,
    output logic              din
);
    localparam int CNT_MAX = (CONV_CYCLES > SHIFT_CYCLES) ? CONV_CYCLES : SHIFT_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX);

    state_t           state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [CFG_W-1:0] cfg, cfg_tx;
    logic             take, din_nxt;

    assign take = start && (state == ST_IDLE || state == ST_DONE);
    assign done = (state == ST_DONE);

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt + 1'b1;
        case (state)
            ST_IDLE: begin
                cnt_nxt = '0;
                if (start) state_nxt = ST_CONV;
            end
            ST_CONV: begin
                if (cnt == CNT_W'(CONV_CYCLES - 1)) begin
                    state_nxt = ST_SHIFT;
                    cnt_nxt   = '0;
                end
            end
            ST_SHIFT: begin
                if (cnt == CNT_W'(SHIFT_CYCLES - 1)) begin
                    state_nxt = ST_DONE;
                    cnt_nxt   = '0;
                end
            end
            ST_DONE: begin
                cnt_nxt   = '0;
                state_nxt = start ? ST_CONV : ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Pin outputs are registered from next-state values so they line up with the state they describe.
    always_comb begin
        cfg_tx  = cfg << cnt_nxt[CNT_W-1:1];
        din_nxt = (state_nxt == ST_SHIFT) && (cnt_nxt < CNT_W'(2 * CFG_W)) && cfg_tx[CFG_W-1];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            cnt   <= '0;
            cfg   <= '0;
            data  <= '0;
            cs    <= 1'b0;
            sclk  <= 1'b0;
            din   <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (take) cfg <= cfg_word(ch, uni);
            if (state == ST_SHIFT && cnt[0]) data <= {data[DATA_W-2:0], dout};
            cs    <= (state_nxt == ST_CONV);
            sclk  <= (state_nxt == ST_SHIFT) && cnt_nxt[0];
            din   <= din_nxt;
        end
    end
endmodule

// File: rtl/adc_scan_sched.sv
// Scan scheduler: latches the channel mask, walks enabled channels frame by frame and publishes
// results one frame late to match the ADC's pipelined conversion.
module adc_scan_sched
    import adc_pkg::*;
#(
    parameter int CONV_CYCLES = 4,
    parameter int NCH         = adc_pkg::NCH
) (
    input  logic              iCLK,
    input  logic              iRST,
    input  logic              iGO,
    input  logic              iCONT,
    input  logic [NCH-1:0]    iCH_MASK,
    input  logic              iUNI,
    output logic              oCS,
    output logic              oSCLK,
    output logic              oDIN,
    input  logic              iDOUT,
    output logic [DATA_W-1:0] oDATA,
    output logic [CH_W-1:0]   oCH,
    output logic              oVALID,
    output logic              oSCAN_DONE,
    output logic              oBUSY
);
    state_t            state;
    logic              frame_done, frame_start;
    logic [DATA_W-1:0] frame_data, data_q;
    logic [NCH-1:0]    mask_q, sel_mask;
    logic [CH_W-1:0]   cur_ch, prev_ch, ch_q, first_ch, last_ch, above_ch, start_ch;
    logic              prev_valid, go_ok, publish, pass_end, wrap, cont;

    assign go_ok    = iGO && (state == ST_IDLE) && (|iCH_MASK);
    assign publish  = frame_done && prev_valid;
    assign pass_end = publish && (prev_ch == last_ch);
    assign wrap     = pass_end && iCONT && (|iCH_MASK);
    assign cont     = frame_done && (!pass_end || wrap);
    assign sel_mask = (go_ok || wrap) ? iCH_MASK : mask_q;

    always_comb begin
        first_ch = '0;
        last_ch  = '0;
        for (int i = NCH - 1; i >= 0; i--)
            if (sel_mask[i]) first_ch = CH_W'(i);
        for (int i = 0; i < NCH; i++)
            if (mask_q[i]) last_ch = CH_W'(i);
        // Lowest enabled channel above the current one, else wrap to the lowest enabled.
        above_ch = first_ch;
        for (int i = NCH - 1; i >= 0; i--)
            if (sel_mask[i] && CH_W'(i) > cur_ch) above_ch = CH_W'(i);
        start_ch    = go_ok ? first_ch : above_ch;
        frame_start = go_ok || cont;
    end

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            mask_q     <= '0;
            cur_ch     <= '0;
            prev_ch    <= '0;
            prev_valid <= 1'b0;
            data_q     <= '0;
            ch_q       <= '0;
        end else begin
            if (go_ok) begin
                mask_q     <= iCH_MASK;
                cur_ch     <= first_ch;
                prev_valid <= 1'b0;
            end
            if (frame_done) begin
                if (cont) begin
                    prev_ch    <= cur_ch;
                    prev_valid <= 1'b1;
                    cur_ch     <= above_ch;
                    if (wrap) mask_q <= iCH_MASK;
                end else begin
                    prev_valid <= 1'b0;
                end
            end
            if (publish) begin
                data_q <= frame_data;
                ch_q   <= prev_ch;
            end
        end
    end

    assign oVALID     = publish;
    assign oSCAN_DONE = pass_end;
    assign oDATA      = publish ? frame_data : data_q;
    assign oCH        = publish ? prev_ch : ch_q;
    assign oBUSY      = (state != ST_IDLE);

    adc_frame #(.CONV_CYCLES(CONV_CYCLES)) u_frame (
        .clk   (iCLK),
        .rst   (iRST),
        .start (frame_start),
        .ch    (start_ch),
        .uni   (iUNI),
        .dout  (iDOUT),
        .state (state),
        .done  (frame_done),
        .data  (frame_data),
        .cs    (oCS),
        .sclk  (oSCLK),
        .din   (oDIN)
    );
endmodule

// File: doc/adc_scan_sched.md
ADC_SCAN_SCHED -- requirements
Module: adc_scan_sched

Interface
REQ-001 Parameter CONV_CYCLES, default 4: iCLK cycles oCS is held high for ADC conversion per frame.
REQ-002 Parameter NCH, default 8: number of ADC input channels.
REQ-003 iCLK  in  1  sole clock. All logic is on rising edges; there is no other clock domain.
REQ-004 iRST  in  1  synchronous, active-high reset.
REQ-005 iGO  in  1  one-cycle pulse that starts a scan pass.
REQ-006 iCONT  in  1  continuous mode: each scan pass chains into the next with no idle gap.
REQ-007 iCH_MASK  in  8  channel enable mask; bit n enables channel n.
REQ-008 iUNI  in  1  unipolar (1) or bipolar (0) configuration bit.
REQ-009 oCS  out  1  conversion-start / chip-select to the ADC.
REQ-010 oSCLK  out  1  serial clock to the ADC, driven from a register.
REQ-011 oDIN  out  1  configuration bit to the ADC.
REQ-012 iDOUT  in  1  serial data from the ADC, MSB first.
REQ-013 oDATA  out  12  latest conversion result.
REQ-014 oCH  out  3  channel that produced oDATA.
REQ-015 oVALID  out  1  one-cycle strobe that accompanies a new oDATA/oCH.
REQ-016 oSCAN_DONE  out  1  one-cycle strobe asserted on the same cycle as the last result of a pass.
REQ-017 oBUSY  out  1  high whenever the FSM is not in IDLE.

Function
REQ-018 FSM states and transitions:
- IDLE -> CONV, when a start is accepted.
- CONV lasts exactly CONV_CYCLES cycles: oCS=1, oSCLK=0.
- SHIFT lasts exactly 24 cycles: oCS=0.
- DONE lasts 1 cycle, then goes to CONV or IDLE.
- Frame length is CONV_CYCLES+25 cycles.
REQ-019 SHIFT cycle index s=0..23. oSCLK=s[0], giving 12 SCLK pulses.
REQ-020 oDIN during SHIFT:
- Config bit b (b=0..5) is driven during s=2b and s=2b+1.
- The 6-bit config word, in transmit order, is {1, ch[0], ch[2], ch[1], iUNI, 0}.
- oDIN=0 for s>=12 and in every non-SHIFT state.
REQ-021 iDOUT is registered at the end of cycle s=2k+1 into result bit 11-k (k=0..11).
REQ-022 The ADC is pipelined: the result shifted in during a frame belongs to the channel configured in the previous frame.
- The scheduler keeps a prev_ch register and a prev_valid flag.
REQ-023 In DONE, if prev_valid=1:
- oDATA = shifted result, oCH = prev_ch, oVALID = 1 for that single cycle.
- oDATA and oCH hold their values until the next oVALID.
REQ-024 Start acceptance:
- iGO is accepted only in IDLE and only when iCH_MASK != 0.
- iGO while busy is ignored; iGO with mask=0 is ignored and oBUSY stays 0.
REQ-025 The mask is latched when a start is accepted and again at every pass wrap in continuous mode. Mask changes mid-pass have no effect.
REQ-026 First frame of a start: config = lowest enabled channel, prev_valid=0. The result of this dummy frame is discarded.
REQ-027 Next config channel = lowest enabled index strictly greater than the current one, wrapping to the lowest enabled index.
- After the last enabled channel is configured, the next frame sends the lowest enabled channel (wrap).
REQ-028 The pass ends in the DONE that publishes the last enabled channel; oSCAN_DONE=1 on that cycle.
- If iCONT=1 on that cycle: next state is CONV, prev_valid stays 1, and there is no dummy frame.
- Otherwise: next state is IDLE.
REQ-029 Single-channel mask: every frame configures that one channel. Each pass yields one oVALID together with oSCAN_DONE.
REQ-030 iCONT falling mid-pass: the current pass completes, then the FSM goes to IDLE.

Reset
REQ-031 When iRST=1, on the next edge, from any state:
- State=IDLE.
- oCS=0, oSCLK=0, oDIN=0.
- oDATA=0, oCH=0, oVALID=0, oSCAN_DONE=0, oBUSY=0, prev_valid=0.
REQ-032 Reset mid-frame abandons the frame with no strobe. A start needs a fresh iGO after iRST falls.

Structure
REQ-033 Shared package adc_pkg holds NCH, DATA_W=12, CFG_W=6, SHIFT_CYCLES=24 and the FSM state enum.
REQ-034 Sub-module adc_frame holds the CONV/SHIFT timing and the shift registers:
- Inputs: start, ch, uni.
- Outputs: done, data.
REQ-035 adc_scan_sched holds the mask latch, channel selection, pipeline tracking and strobes.

Verification
REQ-036 mask=8'h80, iGO, iDOUT model returns 12'hABC -> 2 frames; oVALID once with oCH=7, oDATA=12'hABC, plus oSCAN_DONE; second frame DIN=6'b111110.
REQ-037 mask=8'h25, model returns 12'h100+channel -> results ch0=12'h100, ch2=12'h102, ch5=12'h105 in order; oSCAN_DONE with ch5; oBUSY for 4 frames (4*(CONV_CYCLES+25) cycles).
REQ-038 mask=8'h03, iCONT=1 for 3 passes -> results ch0,ch1 repeating; oSCAN_DONE every 2 frames after the first; exactly one dummy frame.
REQ-039 mask=0, iGO -> oBUSY=0, no oCS activity; then iGO during busy with mask=8'h01 -> the second iGO is ignored.
REQ-040 Reset at SHIFT s=10 -> next cycle all outputs 0, state IDLE, no oVALID; a new iGO restarts with a dummy frame.
